// File: rtl/i2s_pkg.sv
// i2s_pkg: frame geometry and FSM state shared by the I2S transmitter files
package i2s_pkg;
  localparam int SLOT_W = 32;
  localparam int FRAME_BITS = 64;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: show-ahead synchronous FIFO of stereo pairs with full/empty flags
module i2s_tx_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/i2s_codec_tx.sv
// i2s_codec_tx: stereo I2S transmitter to an audio codec; BCLK divider, frame FSM, serializer.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified slots instead of the I2S one-bit delay.
import i2s_pkg::*;
module i2s_codec_tx #(
  parameter int DATA_W = 24,
  parameter int BCLK_DIV = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              audio_bclk,
  output logic              audio_adclrc,
  output logic              audio_daclrc,
  output logic              audio_adcdat,
  output logic              underrun,
  input  logic              underrun_clr
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int PAIR_W = 2 * DATA_W;
  state_t state, state_nxt;
  logic [DIV_W-1:0] div;
  logic [5:0] bit_cnt, next_cnt;
  logic [PAIR_W-1:0] pair, head, cur_pair;
  logic [DATA_W-1:0] sample;
  logic [SLOT_W-1:0] word;
  logic full, empty, tick, fall, wrap, stop, start, ser_bit;
  i2s_tx_fifo #(.W(PAIR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk), .rst(reset_reset), .wr_en(s_valid), .wr_data({s_left, s_right}),
    .rd_en(start), .rd_data(head), .full(full), .empty(empty)
  );
  assign s_ready = !full;
  assign audio_daclrc = audio_adclrc;
  assign tick = state == RUN && div == DIV_W'(BCLK_DIV - 1);
  assign fall = tick && audio_bclk;
  assign wrap = fall && bit_cnt == 6'(FRAME_BITS - 1);
  assign stop = wrap && !enable;
  assign start = wrap && enable;
  assign next_cnt = bit_cnt + 6'd1;
  // The popped pair must drive bit 0 on the same edge it is latched
  assign cur_pair = start ? (empty ? '0 : head) : pair;
  assign sample = next_cnt[5] ? cur_pair[DATA_W-1:0] : cur_pair[PAIR_W-1:DATA_W];
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  assign word = {sample, {(SLOT_W - DATA_W){1'b0}}};
`else
  assign word = {1'b0, sample, {(SLOT_W - 1 - DATA_W){1'b0}}};
`endif
  assign ser_bit = word[~next_cnt[4:0]];
  always_comb begin
    state_nxt = (state == IDLE) ? (enable ? RUN : IDLE) : (stop ? IDLE : RUN);
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      div <= '0;
      bit_cnt <= '0;
      audio_bclk <= 1'b0;
      audio_adclrc <= 1'b0;
      audio_adcdat <= 1'b0;
      pair <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= !underrun_clr && (underrun || (start && empty));
      if (state == IDLE) begin
        div <= '0;
        audio_bclk <= 1'b0;
        audio_adclrc <= 1'b0;
        audio_adcdat <= 1'b0;
        bit_cnt <= enable ? 6'(FRAME_BITS - 1) : 6'd0;
      end else if (tick) begin
        div <= '0;
        audio_bclk <= !audio_bclk;
        if (audio_bclk) begin
          bit_cnt <= next_cnt;
          audio_adclrc <= !stop && next_cnt[5];
          audio_adcdat <= !stop && ser_bit;
          if (start) pair <= cur_pair;
        end
      end else div <= div + 1'b1;
    end
endmodule

// File: tb/tb_i2s_codec_tx.sv
// tb_i2s_codec_tx: scoreboard bench; pairs queued on accept, expanded to expected bits per frame
module tb_i2s_codec_tx;
  localparam int DW = 24, DIV = 2, DEPTH = 4;
  logic clk = 0, rst = 1, enable = 0, s_valid = 0, underrun_clr = 0;
  logic [DW-1:0] s_left = '0, s_right = '0;
  logic s_ready, bclk, adclrc, daclrc, adcdat, underrun;
  int tests = 0, fails = 0;
  logic [2*DW-1:0] fifo_q[$];
  logic exp_underrun = 0;

  always #5 clk = ~clk;

  i2s_codec_tx #(.DATA_W(DW), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk(clk), .reset_reset(rst), .enable(enable), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready), .audio_bclk(bclk), .audio_adclrc(adclrc),
    .audio_daclrc(daclrc), .audio_adcdat(adcdat), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  function automatic logic model_bit(logic [DW-1:0] s, int k);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return (k < DW) ? s[DW-1-k] : 1'b0;
`else
    return (k >= 1 && k <= DW) ? s[DW-k] : 1'b0;
`endif
  endfunction

  task automatic wait_rise(output int cyc);
    logic prev;
    prev = bclk;
    cyc = 0;
    while (cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (!prev && bclk) return;
      prev = bclk;
    end
    tests++; fails++;
    $display("FAIL bclk_timeout: no BCLK rise in %0d clocks, required one", cyc);
    cyc = -1;
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, output logic acc);
    logic exp_ready;
    @(negedge clk);
    s_left = l; s_right = r; s_valid = 1;
    exp_ready = fifo_q.size() < DEPTH;
    tests++;
    if (s_ready !== exp_ready) begin
      fails++;
      $display("FAIL s_ready: got %b, expected %b (model level %0d)", s_ready, exp_ready, fifo_q.size());
    end
    acc = s_ready;
    if (exp_ready) fifo_q.push_back({l, r});
    @(posedge clk);
    #1 s_valid = 0;
  endtask

  task automatic check_idle(input string name);
    int bad = 0;
    repeat (4) @(negedge clk);
    repeat (12) begin
      @(negedge clk);
      if (bclk | adclrc | daclrc | adcdat) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL %s_idle: %0d samples with outputs active, expected 0", name, bad);
    end
  endtask

  task automatic run_frames(input int n, input int drop);
    int cyc;
    logic [2*DW-1:0] p;
    logic e, l;
    enable = 1;
    wait_rise(cyc);
    for (int f = 0; f < n; f++) begin
      if (fifo_q.size() != 0) p = fifo_q.pop_front();
      else begin
        p = '0;
        exp_underrun = 1;
      end
      for (int b = 0; b < 64; b++) begin
        wait_rise(cyc);
        if (cyc < 0) begin
          enable = 0;
          return;
        end
        if (f == 0 && b < 4) begin
          tests++;
          if (cyc !== 2 * DIV) begin
            fails++;
            $display("FAIL bclk_period: got %0d clocks, expected %0d", cyc, 2 * DIV);
          end
        end
        l = b >= 32;
        e = model_bit(l ? p[DW-1:0] : p[2*DW-1:DW], b % 32);
        tests++;
        if ({adclrc, daclrc, adcdat} !== {l, l, e}) begin
          fails++;
          $display("FAIL frame%0d_bit%0d: got lrc=%b daclrc=%b dat=%b, expected lrc=%b dat=%b",
                   f, b, adclrc, daclrc, adcdat, l, e);
        end
        if (b == 0) begin
          tests++;
          if (underrun !== exp_underrun) begin
            fails++;
            $display("FAIL underrun_frame%0d: got %b, expected %b", f, underrun, exp_underrun);
          end
        end
        if (f == n - 1 && b == drop) enable = 0;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({bclk, adclrc, daclrc, adcdat, underrun, s_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_hold: got %b, expected 000001", {bclk, adclrc, daclrc, adcdat, underrun, s_ready});
    end
    @(negedge clk) rst = 0;
    check_idle("post_reset");
  endtask

  task automatic test_frame();
    logic acc;
    push_pair(24'hA5A5A5, 24'h5A5A5A, acc);
    run_frames(1, 40);
    check_idle("frame");
  endtask

  task automatic test_underrun();
    run_frames(1, 20);
    check_idle("underrun");
    @(negedge clk) underrun_clr = 1;
    @(negedge clk) underrun_clr = 0;
    exp_underrun = 0;
    tests++;
    if (underrun !== 1'b0) begin
      fails++;
      $display("FAIL underrun_clr: got %b, expected 0", underrun);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    logic acc;
    for (int i = 0; i < 6; i++) begin
      push_pair(DW'(24'h100000 + i * 24'h012345), DW'(24'h0F0F00 ^ (i * 24'h111111)), acc);
      accepted += int'(acc);
    end
    tests++;
    if (accepted !== 4) begin
      fails++;
      $display("FAIL backpressure_count: got %0d accepted, expected 4", accepted);
    end
  endtask

  task automatic test_enable_drop();
    logic acc;
    run_frames(1, 10);
    check_idle("enable_drop");
    push_pair(24'h7FFFFF, 24'h800001, acc);
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL level_after_drop: s_ready got %b, expected 0", s_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_frames(4, 30);
    check_idle("back_to_back");
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic acc;
    push_pair(24'hFFFFFF, 24'hFFFFFF, acc);
    push_pair(24'h123456, 24'h654321, acc);
    enable = 1;
    for (int i = 0; i < 42 && cyc >= 0; i++) wait_rise(cyc);
    #1 rst = 1;
    #1;
    tests++;
    if ({bclk, adclrc, daclrc, adcdat, underrun, s_ready} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_mid: got %b, expected 000001", {bclk, adclrc, daclrc, adcdat, underrun, s_ready});
    end
    enable = 0;
    fifo_q.delete();
    exp_underrun = 0;
    @(negedge clk) rst = 0;
    run_frames(1, 5);
    check_idle("reset_mid");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_backpressure();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
